// File: rtl/pixel_scan_collector.sv
// rtl/pixel_scan_collector.sv - raster pixel issue with fixed-latency hit capture into a framebuffer
module pixel_scan_collector #(
  parameter int H_RES    = 800,
  parameter int V_RES    = 600,
  parameter int PIPE_LAT = 8
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        issue_valid,
  input  logic        hit_in,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic        fb_data,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [9:0]  X_MAX     = 10'(H_RES - 1);
  localparam logic [9:0]  Y_MAX     = 10'(V_RES - 1);
  localparam logic [18:0] LAST_ADDR = 19'(H_RES * V_RES - 1);

  state_t      state, state_next;
  logic [9:0]  x, y;
  logic [18:0] addr;
  logic        last_pixel;

  logic [PIPE_LAT-1:0] dl_valid;
  logic [18:0]         dl_addr [PIPE_LAT];

  assign last_pixel = (x == X_MAX) && (y == Y_MAX);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    issue_valid = 1'b0;
    busy        = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: if (start) state_next = ISSUE;
      ISSUE: begin
        busy        = 1'b1;
        issue_valid = !pause;
        if (!pause && last_pixel) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (fb_we && fb_addr == LAST_ADDR) state_next = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The final pixel does not advance the counters so pixel_x/pixel_y hold it through DRAIN.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (state == IDLE && start) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (issue_valid && !last_pixel) begin
      addr <= addr + 19'd1;
      if (x == X_MAX) begin
        x <= '0;
        y <= y + 10'd1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      dl_valid <= '0;
      for (int i = 0; i < PIPE_LAT; i++) dl_addr[i] <= '0;
    end else begin
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_addr[i]  <= dl_addr[i-1];
      end
      dl_valid[0] <= issue_valid;
      dl_addr[0]  <= addr;
    end
  end

  assign pixel_x = x;
  assign pixel_y = y;
  assign fb_we   = dl_valid[PIPE_LAT-1];
  assign fb_addr = dl_addr[PIPE_LAT-1];
  assign fb_data = hit_in;

endmodule

// File: tb/tb_pixel_scan_collector.sv
// tb/tb_pixel_scan_collector.sv - randomized scoreboard bench for pixel_scan_collector
module tb_pixel_scan_collector;
  localparam int H = 12;
  localparam int V = 3;
  localparam int L = 3;
  localparam int N = H * V;

  logic        sysclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic        pause  = 1'b0;
  logic        hit_in = 1'b0;
  logic [9:0]  pixel_x, pixel_y;
  logic        issue_valid, fb_we, fb_data, busy, frame_done;
  logic [18:0] fb_addr;

  pixel_scan_collector #(.H_RES(H), .V_RES(V), .PIPE_LAT(L)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .start(start), .pause(pause),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .issue_valid(issue_valid),
    .hit_in(hit_in), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 sysclk = ~sysclk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Reference model: frame progress as counts plus a queue of issued (cycle, address) pairs.
  int cyc = 0;
  bit m_in_frame = 0, m_done = 0;
  int m_issued = 0, m_paused = 0, start_cyc = 0;
  int q_cyc[$], q_addr[$];
  int we_count = 0, first_issue_cyc = -1, first_we_cyc = -1;

  always @(negedge sysclk) begin
    bit exp_iv, exp_we, final_write;
    int p, a;
    cyc++;
    if (!rst_n) begin
      chk("rst_issue_valid", issue_valid, 0);
      chk("rst_fb_we", fb_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_pixel_x", pixel_x, 0);
      chk("rst_pixel_y", pixel_y, 0);
      m_in_frame = 0; m_done = 0; m_issued = 0;
      q_cyc.delete(); q_addr.delete();
    end else begin
      exp_iv = m_in_frame && (m_issued < N) && !pause;
      p      = (m_issued < N) ? m_issued : N - 1;
      exp_we = (q_cyc.size() > 0) && (q_cyc[0] + L == cyc);
      chk("issue_valid", issue_valid, exp_iv);
      chk("pixel_x", pixel_x, p % H);
      chk("pixel_y", pixel_y, p / H);
      chk("busy", busy, m_in_frame);
      chk("frame_done", frame_done, m_done);
      chk("fb_we", fb_we, exp_we);
      final_write = 0;
      if (exp_we) begin
        a = q_addr.pop_front();
        void'(q_cyc.pop_front());
        chk("fb_addr", fb_addr, a);
        chk("fb_data", fb_data, hit_in);
        final_write = (a == N - 1);
      end
      if (fb_we) begin
        we_count++;
        if (first_we_cyc < 0) first_we_cyc = cyc;
      end
      if (issue_valid && first_issue_cyc < 0) first_issue_cyc = cyc;
      if (frame_done) chk("frame_latency", cyc - start_cyc, N + L + 1 + m_paused);

      if (m_done) begin
        m_done = 0;
      end else if (!m_in_frame) begin
        if (start) begin
          m_in_frame = 1; m_issued = 0; m_paused = 0; start_cyc = cyc;
          we_count = 0; first_issue_cyc = -1; first_we_cyc = -1;
        end
      end else begin
        if (m_issued < N && pause) m_paused++;
        if (exp_iv) begin
          q_cyc.push_back(cyc);
          q_addr.push_back(m_issued);
          m_issued++;
        end
        if (final_write) begin
          m_in_frame = 0;
          m_done = 1;
        end
      end
    end
  end

  task automatic tick;
    @(posedge sysclk);
    #1;
    hit_in = 1'($urandom);
  endtask

  task automatic wait_done(input int max_cycles, input bit rnd);
    int n = 0;
    while (n < max_cycles) begin
      tick;
      n++;
      if (frame_done) break;
      if (rnd) begin
        pause = ($urandom_range(9) < 3);
        start = ($urandom_range(7) == 0);
      end
    end
    chk("frame_done_seen", frame_done, 1);
    pause = 0;
    start = 0;
  endtask

  initial begin
    int w, b, idle_cnt;
    repeat (3) tick;
    rst_n = 1;
    tick;

    // Plain frame: wrap points, first write offset, write count.
    start = 1; tick; start = 0;
    repeat (11) tick;
    chk("px_11", pixel_x, 11); chk("py_11", pixel_y, 0); chk("iv_11", issue_valid, 1);
    tick;
    chk("px_wrap", pixel_x, 0); chk("py_wrap", pixel_y, 1);
    wait_done(200, 0);
    chk("we_count_a", we_count, N);
    chk("first_we_offset", first_we_cyc - first_issue_cyc, L);
    repeat (3) tick;

    // Five-cycle pause at pixel (10,0).
    start = 1; tick; start = 0;
    repeat (10) tick;
    pause = 1;
    tick;
    chk("pause_px", pixel_x, 10); chk("pause_iv", issue_valid, 0);
    repeat (4) tick;
    pause = 0;
    wait_done(200, 0);
    chk("we_count_b", we_count, N);
    repeat (2) tick;

    // Random pause and stray start pulses during the frame.
    for (int f = 0; f < 3; f++) begin
      start = 1; tick; start = 0;
      wait_done(400, 1);
      chk("we_count_rnd", we_count, N);
      repeat ($urandom_range(4, 1)) tick;
    end

    // Reset mid-frame drops in-flight results.
    start = 1; tick; start = 0;
    repeat (20) tick;
    rst_n = 0; tick; tick; rst_n = 1;
    w = 0; b = 0;
    repeat (20) begin tick; w += int'(fb_we); b += int'(busy); end
    chk("post_reset_we", w, 0);
    chk("post_reset_busy", b, 0);

    // Start held high: back-to-back frames with a single IDLE gap.
    start = 1;
    wait_done(200, 0);
    start = 1;
    idle_cnt = 0;
    for (int n = 0; n < 200; n++) begin
      tick;
      if (frame_done) break;
      if (!busy) idle_cnt++;
    end
    chk("second_done", frame_done, 1);
    chk("idle_gap", idle_cnt, 1);
    chk("we_count_e", we_count, N);
    start = 0;
    repeat (5) tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
